// File: rtl/pq_ctrl_if.sv
// rtl/pq_ctrl_if.sv - stream and sorted-queue pin bundle for pq_ctrl
interface pq_ctrl_if #(
    parameter int WIDTH = 1
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic [WIDTH-1:0] pq_newVal;
    logic             pq_loadIn;
    logic             pq_shiftOut;
    logic             pq_clear;
    logic [WIDTH-1:0] pq_top;

    modport master (
        output in_valid, in_data, in_last, out_ready, pq_top,
        input  in_ready, out_valid, out_data, pq_newVal, pq_loadIn, pq_shiftOut, pq_clear
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready, pq_top,
        output in_ready, out_valid, out_data, pq_newVal, pq_loadIn, pq_shiftOut, pq_clear
    );
endinterface

// File: rtl/pq_ctrl.sv
// rtl/pq_ctrl.sv - batch fill/drain controller for the priQueue sorted queue
// Define PQ_CTRL_STREAM_EN for FSM-less streaming mode (pop has priority over load).
module pq_ctrl #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 6,
    parameter int CW    = $clog2(DEPTH+1)
) (
    input  logic          ck,
    input  logic          r,
    input  logic          flush,
    pq_ctrl_if.slave      bus,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic          load;
    logic          pop;
    logic [CW-1:0] count_d;

`ifdef PQ_CTRL_STREAM_EN
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        if (!(r || flush)) begin
            bus.out_valid = (count != '0);
            bus.in_ready  = (count < DEPTH_C) && !(bus.out_valid && bus.out_ready);
        end
        load = bus.in_valid && bus.in_ready;
        pop  = bus.out_valid && bus.out_ready;
    end

    always_ff @(posedge ck) begin
        if (r || flush) begin
            count <= '0;
        end else begin
            count <= count_d;
        end
    end
`else
    typedef enum logic {FILL, DRAIN} state_t;
    state_t state, state_d;

    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        state_d       = state;
        if (!(r || flush)) begin
            case (state)
                FILL:  bus.in_ready  = (count < DEPTH_C);
                DRAIN: bus.out_valid = (count != '0);
                default: ;
            endcase
        end
        load = bus.in_valid && bus.in_ready;
        pop  = bus.out_valid && bus.out_ready;
        case (state)
            FILL: begin
                if (load && (bus.in_last || count == DEPTH_C - 1'b1)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Empty DRAIN is unreachable in normal use; fall back to FILL.
                if (count == '0 || (pop && count == CW'(1))) begin
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge ck) begin
        if (r || flush) begin
            count <= '0;
            state <= FILL;
        end else begin
            count <= count_d;
            state <= state_d;
        end
    end
`endif

    assign count_d         = count + CW'(load) - CW'(pop);
    assign bus.out_data    = bus.pq_top;
    assign bus.pq_loadIn   = load;
    assign bus.pq_shiftOut = pop;
    assign bus.pq_newVal   = load ? bus.in_data : '0;
    assign bus.pq_clear    = r || flush;
    assign full            = (count == DEPTH_C);
    assign empty           = (count == '0);
endmodule

// File: tb/tb_pq_ctrl.sv
// tb/tb_pq_ctrl.sv - directed bench for pq_ctrl with a behavioural sorted queue
module tb_pq_ctrl;
    localparam int WIDTH = 4;
    localparam int DEPTH = 6;
    localparam int CW    = $clog2(DEPTH+1);

    logic          ck = 1'b0;
    logic          r;
    logic          flush;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    int            checks = 0;
    int            errors = 0;
    int            hist [0:15];

    pq_ctrl_if #(.WIDTH(WIDTH)) bus ();

    pq_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .ck    (ck),
        .r     (r),
        .flush (flush),
        .bus   (bus.slave),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always #5 ck = ~ck;

    // Queue model: value histogram, top is the largest present value.
    always_comb begin
        bus.pq_top = '0;
        for (int i = 0; i < 16; i++) begin
            if (hist[i] != 0) bus.pq_top = 4'(i);
        end
    end

    always @(posedge ck) begin
        if (bus.pq_clear) begin
            for (int i = 0; i < 16; i++) hist[i] <= 0;
        end else if (bus.pq_loadIn) begin
            hist[bus.pq_newVal] <= hist[bus.pq_newVal] + 1;
        end else if (bus.pq_shiftOut) begin
            hist[bus.pq_top] <= hist[bus.pq_top] - 1;
        end
    end

    always @(negedge ck) begin
        assert (!(bus.pq_loadIn && bus.pq_shiftOut)) else begin
            errors++;
            $error("FAIL load_shift_excl: observed both high expected exclusive");
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    task automatic load_one(input logic [3:0] v, input logic last);
        bus.in_valid = 1'b1;
        bus.in_data  = v;
        bus.in_last  = last;
        #2;
        chk("load_ready", 32'(bus.in_ready), 1);
        chk("load_pulse", 32'(bus.pq_loadIn), 1);
        chk("load_newval", 32'(bus.pq_newVal), 32'(v));
        tick();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_data  = '0;
    endtask

    task automatic pop_one(input logic [3:0] v);
        bus.out_ready = 1'b1;
        #2;
        chk("pop_valid", 32'(bus.out_valid), 1);
        chk("pop_data", 32'(bus.out_data), 32'(v));
        chk("pop_shift", 32'(bus.pq_shiftOut), 1);
        chk("pop_in_ready", 32'(bus.in_ready), 0);
        tick();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) hist[i] = 0;
        r = 1'b1;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.in_last = 1'b0;
        bus.out_ready = 1'b0;

        #2;
        chk("rst_clear0", 32'(bus.pq_clear), 1);
        chk("rst_in_ready", 32'(bus.in_ready), 0);
        tick();
        chk("rst_clear1", 32'(bus.pq_clear), 1);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        tick();
        r = 1'b0;
        #2;
        chk("post_count", 32'(count), 0);
        chk("post_empty", 32'(empty), 1);
        chk("post_in_ready", 32'(bus.in_ready), 1);
        chk("post_out_valid", 32'(bus.out_valid), 0);
        chk("post_clear", 32'(bus.pq_clear), 0);
        tick();

`ifndef PQ_CTRL_STREAM_EN
        // Fill to capacity without in_last.
        load_one(4'd3, 1'b0);
        load_one(4'd9, 1'b0);
        load_one(4'd1, 1'b0);
        load_one(4'd7, 1'b0);
        load_one(4'd5, 1'b0);
        load_one(4'd2, 1'b0);
        #2;
        chk("full_flag", 32'(full), 1);
        chk("full_count", 32'(count), 6);
        chk("full_in_ready", 32'(bus.in_ready), 0);
        pop_one(4'd9);
        pop_one(4'd7);
        pop_one(4'd5);
        pop_one(4'd3);
        pop_one(4'd2);
        pop_one(4'd1);
        #2;
        chk("b1_fill_ready", 32'(bus.in_ready), 1);
        chk("b1_empty", 32'(empty), 1);
        chk("b1_out_valid", 32'(bus.out_valid), 0);
        tick();

        // Batch closed by in_last.
        load_one(4'd4, 1'b0);
        load_one(4'd8, 1'b0);
        load_one(4'd6, 1'b1);
        bus.in_valid = 1'b1;
        #2;
        chk("b2_drain_ready", 32'(bus.in_ready), 0);
        chk("b2_no_load", 32'(bus.pq_loadIn), 0);
        bus.in_valid = 1'b0;
        pop_one(4'd8);
        pop_one(4'd6);
        pop_one(4'd4);
        #2;
        chk("b2_fill_ready", 32'(bus.in_ready), 1);
        tick();

        // Backpressure, then flush mid-drain.
        load_one(4'd3, 1'b0);
        load_one(4'd9, 1'b0);
        load_one(4'd1, 1'b0);
        load_one(4'd7, 1'b0);
        load_one(4'd5, 1'b1);
        pop_one(4'd9);
        #2;
        chk("bp_data0", 32'(bus.out_data), 7);
        chk("bp_shift0", 32'(bus.pq_shiftOut), 0);
        chk("bp_count0", 32'(count), 4);
        tick();
        #2;
        chk("bp_data1", 32'(bus.out_data), 7);
        chk("bp_count1", 32'(count), 4);
        tick();
        pop_one(4'd7);
        bus.out_ready = 1'b1;
        flush = 1'b1;
        #2;
        chk("fl_clear", 32'(bus.pq_clear), 1);
        chk("fl_no_shift", 32'(bus.pq_shiftOut), 0);
        chk("fl_out_valid", 32'(bus.out_valid), 0);
        tick();
        flush = 1'b0;
        bus.out_ready = 1'b0;
        #2;
        chk("fl_count", 32'(count), 0);
        chk("fl_in_ready", 32'(bus.in_ready), 1);
        load_one(4'd2, 1'b1);
        pop_one(4'd2);
        #2;
        chk("fl_end_ready", 32'(bus.in_ready), 1);
        chk("fl_end_count", 32'(count), 0);
`else
        // Streaming: pops take priority over loads.
        bus.out_ready = 1'b0;
        load_one(4'd5, 1'b0);
        load_one(4'd3, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_data = 4'd1;
        bus.out_ready = 1'b1;
        #2;
        chk("st_pop0", 32'(bus.out_data), 5);
        chk("st_blk0", 32'(bus.in_ready), 0);
        chk("st_shift0", 32'(bus.pq_shiftOut), 1);
        tick();
        #2;
        chk("st_pop1", 32'(bus.out_data), 3);
        chk("st_blk1", 32'(bus.pq_loadIn), 0);
        tick();
        #2;
        chk("st_load", 32'(bus.pq_loadIn), 1);
        chk("st_idle_shift", 32'(bus.pq_shiftOut), 0);
        tick();
        bus.in_valid = 1'b0;
        #2;
        chk("st_count", 32'(count), 1);
        chk("st_top", 32'(bus.out_data), 1);
`endif
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
